rx_interface: RTL and testbench
===============================

RX_INTERFACE -- requirements
Module: rx_interface

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 9, meaning log2 of the data-buffer depth in 64-bit words (512 words).
REQ-002 SHALL have port user_clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports axi_str_tdata_from_xgmac/tkeep_from_xgmac/tvalid_from_xgmac/tlast_from_xgmac  input  64/8/1/1  MAC receive stream; it has no tready.
REQ-005 SHALL have port axi_str_tuser_from_xgmac  input  1  frame-good flag, sampled only on the tlast beat.
REQ-006 SHALL have ports axi_str_tdata_to_fifo/tkeep_to_fifo/tvalid_to_fifo/tlast_to_fifo  output  64/8/1/1  user-side stream.
REQ-007 SHALL have port axi_str_tready_from_fifo  input  1  user-side backpressure.
REQ-008 SHALL have ports mac_id  input  48  station address; promiscuous_mode_en  input  1  accept all destinations.
REQ-009 SHALL have port rx_fifo_overflow  output  1  one-cycle pulse per dropped frame.
REQ-010 SHALL have port dropped_frame_cnt  output  16  count of dropped frames.

Function
REQ-011 SHALL store-and-forward: no beat of a frame appears on the user side before that frame is committed.
REQ-012 SHALL store each input beat with tvalid=1 (data, keep, last) at wr_ptr; gaps in tvalid mid-frame SHALL be tolerated.
REQ-013 SHALL use FIFO_DEPTH_LOG2+1-bit wr_ptr, commit_ptr and rd_ptr; full = (wr_ptr-rd_ptr)==2^FIFO_DEPTH_LOG2, with wrap by natural modulo arithmetic.
REQ-014 Write FSM SHALL have states IDLE, RECV, DROP: IDLE->RECV on the first valid beat; RECV->IDLE on tlast; RECV->DROP on a valid non-tlast beat arriving while full; DROP->IDLE on tlast.
REQ-015 On a tlast beat in RECV with tuser=1 and the buffer not full, the beat SHALL be written and commit_ptr SHALL become wr_ptr+1 at that edge.
REQ-016 On tlast with tuser=0, a full buffer, or any tlast in DROP, wr_ptr SHALL rewind to commit_ptr, rx_fifo_overflow SHALL pulse for 1 cycle and dropped_frame_cnt SHALL increment, saturating at 16'hFFFF.
REQ-017 A single-beat frame (tvalid and tlast in IDLE) SHALL follow the tlast rules of REQ-015/REQ-016 directly.
REQ-018 A frame of exactly 2^FIFO_DEPTH_LOG2 words arriving into an empty buffer SHALL be accepted.
REQ-019 The read side SHALL read only entries in [rd_ptr, commit_ptr), using a 1-cycle RAM read followed by an output register.
REQ-020 With an empty output register, tvalid_to_fifo SHALL rise exactly 2 cycles after the committing edge.
REQ-021 The read side SHALL sustain one beat per cycle while tready_from_fifo=1.
REQ-022 Output data, keep and last SHALL be held stable while tvalid_to_fifo=1 and tready_from_fifo=0.
REQ-023 A read and a write in the same cycle SHALL both proceed; full SHALL use the pre-edge rd_ptr (conservative).
REQ-024 tready is never driven to the MAC; input beats SHALL never be stalled, only dropped.

Reset
REQ-025 Assertion of reset SHALL immediately set all pointers, dropped_frame_cnt, rx_fifo_overflow and tvalid_to_fifo to 0, and both FSMs to IDLE.
REQ-026 A partial frame or buffered frames present at reset SHALL be discarded and SHALL not be counted as dropped.
REQ-027 After deassertion, a frame whose tvalid beats started before deassertion SHALL be received in DROP until its tlast.

Configuration
REQ-028 With macro RX_MAC_FILTER_EN defined, word 0 bits [47:0] (destination MAC) SHALL be compared to mac_id.
REQ-029 Under RX_MAC_FILTER_EN, a mismatch with promiscuous_mode_en=0 and a non-broadcast address (not 48'hFFFFFFFFFFFF) SHALL send the FSM to DROP, with the drop handled per REQ-016.
REQ-030 Without RX_MAC_FILTER_EN, mac_id and promiscuous_mode_en SHALL be ignored and no comparator logic shall be generated.

Verification
REQ-031 Good 8-beat frame, tuser=1, tready=1 -> 8 identical beats out, tvalid rises 2 cycles after tlast, cnt=0.
REQ-032 8-beat frame with tuser=0, then a good 3-beat frame -> only the 3-beat frame out, overflow pulses once, cnt=1.
REQ-033 tready=0, then 600-beat frame (depth 512) -> dropped, cnt=1, buffer empty; a following 4-beat frame is delivered intact.
REQ-034 tready toggled 50% during a 64-beat frame -> output beats in order, stable while stalled, tlast only on beat 64.
REQ-035 RX_MAC_FILTER_EN, mac_id=48'h000A35000001, promiscuous=0; frames to 48'h000A35000002, broadcast and mac_id -> first dropped, other two delivered; promiscuous=1 -> all delivered.
REQ-036 Reset asserted mid-frame with 2 committed frames buffered -> tvalid_to_fifo=0 immediately, no output after reset, cnt=0.

Source files
------------

// File: rtl/rx_interface.sv
// rx_interface -- store-and-forward receive buffer between a 10G MAC and the
// user-side stream.
//
// Whole frames are written into a circular buffer. A frame becomes visible to
// the read side only after its tlast beat arrives with a good status
// (tuser=1) and the buffer did not fill up while it was arriving. Bad frames,
// and frames that overflow, are rewound out of the buffer. Each such frame
// produces a one-cycle rx_fifo_overflow pulse and a saturating count. The MAC
// side has no tready: beats are never stalled, only dropped.
//
// Optional build macro RX_MAC_FILTER_EN: drop frames whose destination MAC
// (word 0, bits [47:0]) is neither mac_id nor broadcast, unless
// promiscuous_mode_en=1. When the macro is undefined, mac_id and
// promiscuous_mode_en are ignored.
//
// Ports:
//   user_clk, reset                   clock, asynchronous active-high reset
//   axi_str_*_from_xgmac              MAC receive stream (tdata/tkeep/tvalid/
//                                     tlast, tuser = frame good on tlast)
//   axi_str_*_to_fifo                 user-side stream (tdata/tkeep/tvalid/tlast)
//   axi_str_tready_from_fifo          user-side backpressure
//   mac_id, promiscuous_mode_en       address filter controls
//   rx_fifo_overflow                  one-cycle pulse per dropped frame
//   dropped_frame_cnt                 saturating dropped-frame count
module rx_interface #(
  parameter int FIFO_DEPTH_LOG2 = 9
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic [63:0] axi_str_tdata_from_xgmac,
  input  logic [7:0]  axi_str_tkeep_from_xgmac,
  input  logic        axi_str_tvalid_from_xgmac,
  input  logic        axi_str_tlast_from_xgmac,
  input  logic        axi_str_tuser_from_xgmac,
  output logic [63:0] axi_str_tdata_to_fifo,
  output logic [7:0]  axi_str_tkeep_to_fifo,
  output logic        axi_str_tvalid_to_fifo,
  output logic        axi_str_tlast_to_fifo,
  input  logic        axi_str_tready_from_fifo,
  input  logic [47:0] mac_id,
  input  logic        promiscuous_mode_en,
  output logic        rx_fifo_overflow,
  output logic [15:0] dropped_frame_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } entry_t;

  wr_state_t wr_state, wr_state_nxt;
  ptr_t      wr_ptr, commit_ptr, rd_ptr;
  logic      full, addr_ok;
  logic      wr_en, commit_frame, drop_frame, rewind;
  logic      tail_discard, tail_discard_nxt;
  logic      mac_in_frame;
  entry_t    wr_word;

  entry_t    mem [DEPTH];
  entry_t    s1_word, out_word;
  logic      s1_valid, out_valid;
  logic      out_free, s1_to_out, rd_issue;

  // Full compares against the pre-edge rd_ptr, so a same-cycle read only
  // makes room from the next cycle on.
  assign full    = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
  assign wr_word = '{last: axi_str_tlast_from_xgmac,
                     keep: axi_str_tkeep_from_xgmac,
                     data: axi_str_tdata_from_xgmac};

`ifdef RX_MAC_FILTER_EN
  logic [47:0] dest_mac;
  assign dest_mac = axi_str_tdata_from_xgmac[47:0];
  assign addr_ok  = promiscuous_mode_en || (dest_mac == mac_id) ||
                    (dest_mac == 48'hFFFF_FFFF_FFFF);
`else
  logic unused_filter_inputs;
  assign unused_filter_inputs = ^{mac_id, promiscuous_mode_en};
  assign addr_ok = 1'b1;
`endif

  // Tracks whether the MAC stream is between frames. It runs through reset
  // on purpose: the tail of a frame that began before reset deasserts must
  // be recognised and skipped rather than taken as a new frame.
  always_ff @(posedge user_clk) begin
    if (axi_str_tvalid_from_xgmac) mac_in_frame <= !axi_str_tlast_from_xgmac;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_state_nxt     = wr_state;
    tail_discard_nxt = tail_discard;
    wr_en            = 1'b0;
    commit_frame     = 1'b0;
    drop_frame       = 1'b0;
    rewind           = 1'b0;
    case (wr_state)
      IDLE, RECV: begin
        if (axi_str_tvalid_from_xgmac) begin
          if (wr_state == IDLE && mac_in_frame) begin
            // Tail of a frame cut by reset: skip silently.
            if (!axi_str_tlast_from_xgmac) begin
              wr_state_nxt     = DROP;
              tail_discard_nxt = 1'b1;
            end
          end else if (wr_state == IDLE && !addr_ok) begin
            if (axi_str_tlast_from_xgmac) begin
              drop_frame = 1'b1;
              rewind     = 1'b1;
            end else begin
              wr_state_nxt = DROP;
            end
          end else if (axi_str_tlast_from_xgmac) begin
            wr_state_nxt = IDLE;
            if (axi_str_tuser_from_xgmac && !full) begin
              wr_en        = 1'b1;
              commit_frame = 1'b1;
            end else begin
              drop_frame = 1'b1;
              rewind     = 1'b1;
            end
          end else if (full) begin
            wr_state_nxt = DROP;
          end else begin
            wr_en        = 1'b1;
            wr_state_nxt = RECV;
          end
        end
      end
      DROP: begin
        if (axi_str_tvalid_from_xgmac && axi_str_tlast_from_xgmac) begin
          wr_state_nxt     = IDLE;
          rewind           = 1'b1;
          drop_frame       = !tail_discard;
          tail_discard_nxt = 1'b0;
        end
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      wr_state          <= IDLE;
      tail_discard      <= 1'b0;
      wr_ptr            <= '0;
      commit_ptr        <= '0;
      rx_fifo_overflow  <= 1'b0;
      dropped_frame_cnt <= '0;
    end else begin
      wr_state         <= wr_state_nxt;
      tail_discard     <= tail_discard_nxt;
      rx_fifo_overflow <= drop_frame;
      if (drop_frame && dropped_frame_cnt != 16'hFFFF)
        dropped_frame_cnt <= dropped_frame_cnt + 16'd1;
      if (commit_frame) begin
        wr_ptr     <= wr_ptr + ptr_t'(1);
        commit_ptr <= wr_ptr + ptr_t'(1);
      end else if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
    end
  end

  // Read pipeline: RAM read register (s1) feeding the output register. The
  // output register loads only when empty or being consumed, which keeps it
  // stable under backpressure while still allowing one beat per cycle.
  assign out_free  = !out_valid || axi_str_tready_from_fifo;
  assign s1_to_out = s1_valid && out_free;
  assign rd_issue  = (rd_ptr != commit_ptr) && (!s1_valid || s1_to_out);

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + ptr_t'(1);
      s1_valid <= rd_issue || (s1_valid && !s1_to_out);
      if (out_free) out_valid <= s1_valid;
    end
  end

  // NOTE: the buffer and data registers are not reset; the valid flags and
  // pointers alone decide what is live, so the storage can map onto RAM.
  always_ff @(posedge user_clk) begin
    if (wr_en)     mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wr_word;
    if (rd_issue)  s1_word  <= mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    if (s1_to_out) out_word <= s1_word;
  end

  assign axi_str_tdata_to_fifo  = out_word.data;
  assign axi_str_tkeep_to_fifo  = out_word.keep;
  assign axi_str_tlast_to_fifo  = out_word.last;
  assign axi_str_tvalid_to_fifo = out_valid;

endmodule

// File: tb/tb_rx_interface.sv
// Directed testbench for rx_interface (default depth 512 words).
// Expected output beats are built from the same beat-pattern function used
// to generate stimulus, and compared beat by beat against captured output.
module tb_rx_interface;

  logic        user_clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [63:0] tdata_o;
  logic [7:0]  tkeep_o;
  logic        tvalid_o, tlast_o;
  logic        tready = 1'b1;
  logic [47:0] mac_id = 48'h000A_3500_0001;
  logic        promisc = 1'b0;
  logic        ovf;
  logic [15:0] cnt;

  localparam logic [47:0] MY_MAC    = 48'h000A_3500_0001;
  localparam logic [47:0] OTHER_MAC = 48'h000A_3500_0002;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    tests = 0, failed = 0;
  int    ovf_count = 0;
  int    exp_cnt = 0;
  bit    stall_prev = 1'b0;
  logic [73:0] held = '0;

  rx_interface dut (
    .user_clk                  (user_clk),
    .reset                     (reset),
    .axi_str_tdata_from_xgmac  (tdata),
    .axi_str_tkeep_from_xgmac  (tkeep),
    .axi_str_tvalid_from_xgmac (tvalid),
    .axi_str_tlast_from_xgmac  (tlast),
    .axi_str_tuser_from_xgmac  (tuser),
    .axi_str_tdata_to_fifo     (tdata_o),
    .axi_str_tkeep_to_fifo     (tkeep_o),
    .axi_str_tvalid_to_fifo    (tvalid_o),
    .axi_str_tlast_to_fifo     (tlast_o),
    .axi_str_tready_from_fifo  (tready),
    .mac_id                    (mac_id),
    .promiscuous_mode_en       (promisc),
    .rx_fifo_overflow          (ovf),
    .dropped_frame_cnt         (cnt)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] beat_data(input int id, input int i, input logic [47:0] dest);
    if (i == 0) return {16'(id), dest};
    return {16'(id), 16'(i), 32'hC0DE_0000 + 32'(i * 7)};
  endfunction

  // Output monitor: sampled on the falling edge, between DUT updates.
  always @(negedge user_clk) begin
    if (stall_prev && !reset)
      check("hold_stable", {tvalid_o, tdata_o, tkeep_o, tlast_o}, held);
    stall_prev = tvalid_o && !tready;
    held       = {tvalid_o, tdata_o, tkeep_o, tlast_o};
    if (tvalid_o && tready) got_q.push_back('{d: tdata_o, k: tkeep_o, l: tlast_o});
    if (ovf) ovf_count++;
  end

  // Called #1 after a rising edge; returns #1 after the edge that sampled tlast.
  task automatic send_frame(input int id, input int len, input bit good,
                            input logic [47:0] dest, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 3 == 1)) begin
        tvalid = 1'b0;
        @(posedge user_clk); #1;
      end
      tvalid = 1'b1;
      tdata  = beat_data(id, i, dest);
      tkeep  = (i == len - 1) ? 8'h3F : 8'hFF;
      tlast  = (i == len - 1);
      tuser  = (i == len - 1) ? good : 1'b0;
      @(posedge user_clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic push_expected(input int id, input int len, input logic [47:0] dest);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{d: beat_data(id, i, dest), k: (i == len - 1) ? 8'h3F : 8'hFF,
                        l: (i == len - 1)});
  endtask

  task automatic wait_output(input string tag, input int budget);
    int c = 0;
    while (got_q.size() < exp_q.size() && c < budget) begin
      @(posedge user_clk); #1;
      c++;
    end
    repeat (6) begin @(posedge user_clk); #1; end
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_drops(input string tag);
    check({tag, "_cnt"}, 128'(cnt), 128'(exp_cnt));
    check({tag, "_ovf_pulses"}, 128'(ovf_count), 128'(exp_cnt));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_tvalid", 128'(tvalid_o), 128'(0));
    check("rst_ovf", 128'(ovf), 128'(0));
    check("rst_cnt", 128'(cnt), 128'(0));
    reset = 1'b0;
    @(posedge user_clk); #1;

    // Good 8-beat frame; tvalid rises two cycles after the committing edge
    send_frame(1, 8, 1'b1, MY_MAC, 1'b0);
    push_expected(1, 8, MY_MAC);
    check("t1_valid_commit_edge", 128'(tvalid_o), 128'(0));
    @(posedge user_clk); #1;
    check("t1_valid_plus1", 128'(tvalid_o), 128'(0));
    @(posedge user_clk); #1;
    check("t1_valid_plus2", 128'(tvalid_o), 128'(1));
    wait_output("t1", 100);
    check_drops("t1");

    // Bad 8-beat frame then a good 3-beat frame
    send_frame(2, 8, 1'b0, MY_MAC, 1'b0);
    send_frame(3, 3, 1'b1, MY_MAC, 1'b0);
    exp_cnt = 1;
    push_expected(3, 3, MY_MAC);
    wait_output("t2", 100);
    check_drops("t2");

    // Single-beat frames: good one delivered, bad one dropped
    send_frame(4, 1, 1'b1, MY_MAC, 1'b0);
    send_frame(5, 1, 1'b0, MY_MAC, 1'b0);
    exp_cnt = 2;
    push_expected(4, 1, MY_MAC);
    wait_output("t_single", 100);
    check_drops("t_single");

    // Oversize frame with no reads: dropped, buffer left empty
    tready = 1'b0;
    send_frame(6, 600, 1'b1, MY_MAC, 1'b0);
    exp_cnt = 3;
    repeat (5) begin @(posedge user_clk); #1; end
    check_drops("t3_drop");
    check("t3_empty_valid", 128'(tvalid_o), 128'(0));
    send_frame(7, 4, 1'b1, MY_MAC, 1'b0);
    repeat (4) begin @(posedge user_clk); #1; end
    check("t3_held_valid", 128'(tvalid_o), 128'(1));
    check("t3_held_data", 128'(tdata_o), 128'(beat_data(7, 0, MY_MAC)));
    tready = 1'b1;
    push_expected(7, 4, MY_MAC);
    wait_output("t3", 100);

    // Frame of exactly the buffer depth into an empty buffer is accepted
    tready = 1'b0;
    send_frame(8, 512, 1'b1, MY_MAC, 1'b0);
    repeat (3) begin @(posedge user_clk); #1; end
    check_drops("t_depth");
    tready = 1'b1;
    push_expected(8, 512, MY_MAC);
    wait_output("t_depth", 1200);

    // 64-beat frame with input gaps, tready alternating every cycle
    fork
      send_frame(10, 64, 1'b1, MY_MAC, 1'b1);
      for (int c = 0; c < 400; c++) begin
        @(posedge user_clk); #1;
        tready = ~tready;
      end
    join
    tready = 1'b1;
    push_expected(10, 64, MY_MAC);
    wait_output("t4", 200);
    check_drops("t4");

    // Destination filtering
    send_frame(30, 3, 1'b1, OTHER_MAC, 1'b0);
    send_frame(31, 3, 1'b1, BCAST, 1'b0);
    send_frame(32, 3, 1'b1, MY_MAC, 1'b0);
`ifdef RX_MAC_FILTER_EN
    exp_cnt = exp_cnt + 1;
`else
    push_expected(30, 3, OTHER_MAC);
`endif
    push_expected(31, 3, BCAST);
    push_expected(32, 3, MY_MAC);
    wait_output("t5_filter", 100);
    check_drops("t5_filter");
    promisc = 1'b1;
    send_frame(33, 3, 1'b1, OTHER_MAC, 1'b0);
    send_frame(34, 3, 1'b1, BCAST, 1'b0);
    send_frame(35, 3, 1'b1, MY_MAC, 1'b0);
    push_expected(33, 3, OTHER_MAC);
    push_expected(34, 3, BCAST);
    push_expected(35, 3, MY_MAC);
    wait_output("t5_promisc", 100);
    check_drops("t5_promisc");
    promisc = 1'b0;

    // Reset mid-frame with two committed frames buffered
    tready = 1'b0;
    send_frame(20, 3, 1'b1, MY_MAC, 1'b0);
    send_frame(21, 3, 1'b1, MY_MAC, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 7) reset = 1'b0;
      tvalid = 1'b1;
      tdata  = beat_data(22, i, MY_MAC);
      tkeep  = (i == 9) ? 8'h3F : 8'hFF;
      tlast  = (i == 9);
      tuser  = (i == 9);
      if (i == 4) begin
        check("t6_valid_before_rst", 128'(tvalid_o), 128'(1));
        #3 reset = 1'b1;
        #1;
        check("t6_valid_in_rst", 128'(tvalid_o), 128'(0));
        check("t6_cnt_in_rst", 128'(cnt), 128'(0));
        ovf_count = 0;
        exp_cnt   = 0;
        @(posedge user_clk); #1;
      end else begin
        @(posedge user_clk); #1;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    tready = 1'b1;
    wait_output("t6_no_output", 20);
    check("t6_valid_after", 128'(tvalid_o), 128'(0));
    check_drops("t6");
    send_frame(23, 5, 1'b1, MY_MAC, 1'b0);
    push_expected(23, 5, MY_MAC);
    wait_output("t6_recover", 100);
    check_drops("t6_recover");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
